// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: FSM encodings, default widths
// and requester port indices.
package dmem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return (idx == PORT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, and a tie goes to
// the port that was not granted last.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        unique case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two load/store requesters onto the 256x8 data memory, one access
// at a time, and returns read data with a one-cycle completion pulse.
//
//   state  | meaning
//   IDLE   | waiting for a request; winner sees ready and its fields are captured
//   ACCESS | memory driven from captured regs for one cycle; load data registered
//   DONE   | done pulse to the granted port; last_grant updated
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_idx_q, gnt_idx_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0] pick;
    logic [1:0] ready;
    logic [1:0] done;

    rr_arb2 u_rr_arb2 (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (pick)
    );

    assign ready = (state_q == ST_IDLE) ? pick : 2'b00;
    assign done  = (state_q == ST_DONE) ? idx_to_onehot(gnt_idx_q) : 2'b00;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_idx_d    = gnt_idx_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|pick) begin
                    state_d   = ST_ACCESS;
                    gnt_idx_d = pick[1] ? PORT1 : PORT0;
                    wr_d      = pick[1] ? req1_write : req0_write;
                    addr_d    = pick[1] ? req1_addr  : req0_addr;
                    wdata_d   = pick[1] ? req1_wdata : req0_wdata;
                end
            end
            ST_ACCESS: begin
                // Stores echo their own write data back on completion.
                rdata_d = wr_q ? wdata_q : mem_rdata;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                last_grant_d = gnt_idx_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT1;
            gnt_idx_q    <= PORT0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_idx_q    <= gnt_idx_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // Address/data come straight from the capture regs so they never glitch
    // toward the other requester between accesses.
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_write  = (state_q == ST_ACCESS) && wr_q;

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign req0_done  = done[0];
    assign req1_done  = done[1];
    assign req0_rdata = rdata_q;
    assign req1_rdata = rdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the 256×8 data memory. Accepts load/store requests from two masters (port 0: CPU load/store unit, port 1: debug/DMA loader), grants one at a time with round-robin fairness, and drives the memory's address/write-data/write-enable inputs for exactly one access cycle. Returns read data and a completion pulse to the granted requester. Sits between the requesters and the data memory; the memory's combinational read path and level-sensitive write stay untouched.

## Interface
Parameters:
- ADDR_W, 8, address width (memory depth 2^ADDR_W)
- DATA_W, 8, data width

Ports:
- sysclk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_write / req1_write  in  1  1 = store, 0 = load
- req0_addr / req1_addr  in  ADDR_W  target address
- req0_wdata / req1_wdata  in  DATA_W  store data
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_done / req1_done  out  1  one-cycle completion pulse
- req0_rdata / req1_rdata  out  DATA_W  load result, valid while done high
- mem_addr  out  ADDR_W  to memory addr
- mem_wdata  out  DATA_W  to memory writeData
- mem_write  out  1  to memory write
- mem_rdata  in  DATA_W  from memory readData

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state IDLE.
- IDLE: if any valid, pick winner; assert winner's ready combinationally; on that edge capture write/addr/wdata and grant index; go ACCESS. No valid: stay IDLE.
- Arbitration: one valid → it wins. Both valid → the one not granted last wins. last_grant resets to 1, so port 0 wins the first tie.
- ACCESS (exactly 1 cycle): mem_addr/mem_wdata driven from captured regs; mem_write = captured write. For loads, mem_rdata registered into rdata at end of cycle. Go DONE.
- DONE (exactly 1 cycle): granted port's done = 1; its rdata = registered value (stores: rdata returns the written data). Update last_grant. Go IDLE.
- ready only asserted in IDLE, only to winner, at most one port high. Loser keeps valid asserted; it must hold fields stable until its ready.
- rdata outputs shared register value; only meaningful alongside done.

## Timing
- Reset values: all ready/done 0, mem_write 0, mem_addr 0, mem_wdata 0, rdata 0, state IDLE, last_grant 1.
- Accept at edge T (valid & ready) → ACCESS cycle T+1 → done pulse cycle T+2 → IDLE at T+3. Latency 2 cycles accept-to-done; throughput one access per 3 cycles.
- mem_write high only during ACCESS for stores; never in IDLE/DONE, never two consecutive cycles.
- mem_addr/mem_wdata hold captured values outside ACCESS (no glitching to other requester's address).
- Reset mid-operation: state → IDLE next edge; in-flight access abandoned, no done pulse; mem_write 0 from that edge; store may or may not have landed (requester must retry).
- valid deasserted during ACCESS/DONE has no effect on the in-flight transaction.
- Address wrap: ADDR_W-bit, 255 is a valid last address; no range check.

## Structure
- Shared package/header (dmem_pkg): state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), ADDR_W/DATA_W defaults, port index constants.
- One sub-module: rr_arb2 — combinational 2-way round-robin picker (inputs valid[1:0], last_grant; outputs grant one-hot). FSM, capture registers and mem drive live in dmem_arbiter.

## Test plan
- Single store: port 0 store addr 0x10 data 0xA5 → ready0 at T, mem_write=1 with mem_addr 0x10 at T+1 only, done0 at T+2; subsequent port 0 load 0x10 → rdata0 = 0xA5 with done0.
- Tie after reset: both valid (p0 load 0x01, p1 load 0x02) same cycle → p0 served first (done0), p1 next (ready1 at T+3, done1 at T+5).
- Fairness: both valid continuously for 6 transactions → grants alternate 0,1,0,1,0,1; never two ready in one cycle.
- Write isolation: p1 store 0xFF→0x3C while p0 waiting → mem_write never high outside p1's ACCESS; p0 later loads 0xFF → 0x3C.
- Reset in ACCESS: assert reset during store ACCESS → next cycle mem_write 0, state IDLE, no done pulse, last_grant 1.
- Idle quiescence: no valid for 10 cycles → ready/done/mem_write all 0, mem_addr unchanged.
